// File: rtl/rr_arbiter_if.sv
// Handshake bundle between rr_arbiter and the mux/consumer it steers.
// master: arbiter side (drives grant/select/out_valid/ptr, takes req/out_ready).
// slave : requester/consumer side (drives req/out_ready, observes the rest).
interface rr_arbiter_if #(
    parameter int INPUTS = 8,
    parameter int WSEL   = $clog2(INPUTS)
) ();
    logic [INPUTS-1:0] req;
    logic [INPUTS-1:0] grant;
    logic [WSEL-1:0]   select;
    logic              out_valid;
    logic              out_ready;
    logic [WSEL-1:0]   ptr;

    modport master (
        input  req,
        input  out_ready,
        output grant,
        output select,
        output out_valid,
        output ptr
    );

    modport slave (
        output req,
        output out_ready,
        input  grant,
        input  select,
        input  out_valid,
        input  ptr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and binary mux select.
// Ports: clk, reset (async, active-high), bus (rr_arbiter_if.master);
// lock input exists only when the ARB_LOCK_EN macro is defined, and holds
// the current grant across a handshake while the granted request stays up.
module rr_arbiter #(
    parameter int INPUTS = 8,
    parameter int WSEL   = $clog2(INPUTS)
) (
    input  logic clk,
    input  logic reset,
`ifdef ARB_LOCK_EN
    input  logic lock,
`endif
    rr_arbiter_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [INPUTS-1:0] grant_q, grant_d;
    logic [WSEL-1:0]   select_q, select_d;
    logic [WSEL-1:0]   ptr_q, ptr_d;

    logic [WSEL-1:0]   ptr_next;
    logic [INPUTS-1:0] req_other;
    logic [WSEL:0]     pick_idle;
    logic [WSEL:0]     pick_next;
    logic              lock_hold;

    // First set bit of r searching upward from p with wrap.
    // Result is {found, index}.
    function automatic logic [WSEL:0] pick(
        input logic [INPUTS-1:0] r,
        input logic [WSEL-1:0]   p
    );
        logic            found;
        logic [WSEL-1:0] idx;
        int              j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < INPUTS; k++) begin
            j = int'(p) + k;
            if (j >= INPUTS) begin
                j = j - INPUTS;
            end
            if (!found && r[j[WSEL-1:0]]) begin
                found = 1'b1;
                idx   = j[WSEL-1:0];
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        // Explicit wrap so non-power-of-2 widths never leave [0, INPUTS).
        ptr_next  = (select_q == WSEL'(INPUTS - 1)) ? '0 : select_q + 1'b1;
        req_other = bus.req & ~grant_q;
        pick_idle = pick(bus.req, ptr_q);
        pick_next = pick(req_other, ptr_next);
`ifdef ARB_LOCK_EN
        lock_hold = lock && bus.req[select_q];
`else
        lock_hold = 1'b0;
`endif

        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        ptr_d    = ptr_q;

        unique case (state_q)
            IDLE: begin
                if (pick_idle[WSEL]) begin
                    state_d  = GRANT;
                    select_d = pick_idle[WSEL-1:0];
                    grant_d  = INPUTS'(1) << pick_idle[WSEL-1:0];
                end
            end
            GRANT: begin
                // Handshake outranks a same-cycle drop of the granted req.
                if (bus.out_ready) begin
                    if (!lock_hold) begin
                        ptr_d = ptr_next;
                        if (pick_next[WSEL]) begin
                            select_d = pick_next[WSEL-1:0];
                            grant_d  = INPUTS'(1) << pick_next[WSEL-1:0];
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                        end
                    end
                end else if (!bus.req[select_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            select_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.select    = select_q;
    assign bus.ptr       = ptr_q;
    assign bus.out_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter at INPUTS=8, 3 and 4 side by side.
// Expected outputs are queued per cycle and compared after each edge.
module tb_rr_arbiter;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rdy  = 1'b0;
    logic lock = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rr_arbiter_if #(.INPUTS(8)) b8 ();
    rr_arbiter_if #(.INPUTS(3)) b3 ();
    rr_arbiter_if #(.INPUTS(4)) b4 ();

    assign b8.out_ready = rdy;
    assign b3.out_ready = rdy;
    assign b4.out_ready = rdy;

    rr_arbiter #(.INPUTS(8)) u_d8 (
        .clk   (clk),
        .reset (rst),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .bus   (b8)
    );

    rr_arbiter #(.INPUTS(3)) u_d3 (
        .clk   (clk),
        .reset (rst),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .bus   (b3)
    );

    rr_arbiter #(.INPUTS(4)) u_d4 (
        .clk   (clk),
        .reset (rst),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .bus   (b4)
    );

    typedef struct {
        bit st;
        int sel;
        int ptr;
    } mdl_t;

    typedef struct {
        int          id;
        logic [31:0] grant;
        int          sel;
        bit          valid;
        int          ptr;
    } exp_t;

    mdl_t m[3];
    int   nin[3] = '{8, 3, 4};
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: one clock of the arbiter.
    function automatic mdl_t step(input mdl_t c, input int n,
                                  input logic [31:0] r, input bit rd,
                                  input bit lk);
        mdl_t x;
        int   i;
        x = c;
        if (!c.st) begin
            for (int k = 0; k < n; k++) begin
                i = (c.ptr + k) % n;
                if (r[i]) begin
                    x.st  = 1'b1;
                    x.sel = i;
                    return x;
                end
            end
            return x;
        end
        if (rd) begin
            if (lk && r[c.sel]) return x;
            x.ptr = (c.sel + 1) % n;
            x.st  = 1'b0;
            for (int k = 0; k < n; k++) begin
                i = (x.ptr + k) % n;
                if (r[i] && i != c.sel) begin
                    x.st  = 1'b1;
                    x.sel = i;
                    return x;
                end
            end
            return x;
        end
        if (!r[c.sel]) x.st = 1'b0;
        return x;
    endfunction

    task automatic compare(input exp_t e);
        logic [31:0] g, s, p;
        logic        v;
        string       nm;
        nm = $sformatf("d%0d", nin[e.id]);
        case (e.id)
            0: begin
                g = 32'(b8.grant); s = 32'(b8.select);
                p = 32'(b8.ptr);   v = b8.out_valid;
            end
            1: begin
                g = 32'(b3.grant); s = 32'(b3.select);
                p = 32'(b3.ptr);   v = b3.out_valid;
            end
            default: begin
                g = 32'(b4.grant); s = 32'(b4.select);
                p = 32'(b4.ptr);   v = b4.out_valid;
            end
        endcase
        check({nm, "_grant"}, g, e.grant);
        check({nm, "_valid"}, 32'(v), 32'(e.valid));
        check({nm, "_ptr"}, p, 32'(e.ptr));
        if (e.valid) check({nm, "_select"}, s, 32'(e.sel));
    endtask

    task automatic cycle(input logic [31:0] r8, input logic [31:0] r3,
                         input logic [31:0] r4);
        logic [31:0] rq;
        bit          lk;
        exp_t        e;
`ifdef ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        b8.req = r8[7:0];
        b3.req = r3[2:0];
        b4.req = r4[3:0];
        for (int i = 0; i < 3; i++) begin
            rq = (i == 0) ? r8 : (i == 1) ? r3 : r4;
            rq = rq & ((32'h1 << nin[i]) - 32'h1);
            m[i] = step(m[i], nin[i], rq, rdy, lk);
            e.id    = i;
            e.valid = m[i].st;
            e.sel   = m[i].sel;
            e.ptr   = m[i].ptr;
            e.grant = m[i].st ? (32'h1 << m[i].sel) : 32'h0;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compare(sb.pop_front());
        end
    endtask

    // Called between edges: outputs must clear with no clock edge.
    task automatic pulse_reset();
        exp_t e;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            m[i] = '{st: 1'b0, sel: 0, ptr: 0};
            e = '{id: i, grant: 32'h0, sel: 0, valid: 1'b0, ptr: 0};
            compare(e);
        end
        check("rst_sel8", 32'(b8.select), 32'h0);
        check("rst_sel3", 32'(b3.select), 32'h0);
        check("rst_sel4", 32'(b4.select), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        b8.req = '0;
        b3.req = '0;
        b4.req = '0;
        @(negedge clk);
        pulse_reset();

        // Single request, one-cycle latency, ptr advance on handshake.
        rdy = 1'b1;
        cycle(32'h01, 0, 0);
        check("r031_grant", 32'(b8.grant), 32'h01);
        check("r031_valid", 32'(b8.out_valid), 32'h1);
        cycle(0, 0, 0);
        check("r031_ptr", 32'(b8.ptr), 32'h1);
        check("r031_idle", 32'(b8.out_valid), 32'h0);

        // All requesting: back-to-back rotation 0..7,0 from ptr 0.
        @(negedge clk);
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(32'hFF, 0, 0);
            check("r032_sel", 32'(b8.select), 32'(i % 8));
            check("r032_valid", 32'(b8.out_valid), 32'h1);
        end

        // INPUTS=3 wrap: bring ptr to 2, then 3'b011 wraps to source 0.
        cycle(0, 32'b010, 0);
        cycle(0, 0, 0);
        check("r033_ptr2", 32'(b3.ptr), 32'h2);
        rdy = 1'b0;
        cycle(0, 32'b011, 0);
        check("r033_grant", 32'(b3.grant), 32'b001);
        rdy = 1'b1;
        cycle(0, 0, 0);
        check("r033_ptr1", 32'(b3.ptr), 32'h1);

        // INPUTS=4 abort, then reset while granted.
        rdy = 1'b0;
        cycle(0, 0, 32'b0100);
        check("r034_grant", 32'(b4.grant), 32'b0100);
        cycle(0, 0, 32'b0100);
        check("r034_hold", 32'(b4.grant), 32'b0100);
        cycle(0, 0, 0);
        check("r034_abort_g", 32'(b4.grant), 32'h0);
        check("r034_abort_v", 32'(b4.out_valid), 32'h0);
        check("r034_abort_p", 32'(b4.ptr), 32'h0);
        cycle(0, 0, 32'b0100);
        pulse_reset();

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0);
`endif
            cycle($urandom & $urandom, $urandom, $urandom & $urandom);
        end

`ifdef ARB_LOCK_EN
        lock = 1'b0;
        @(negedge clk);
        pulse_reset();
        lock = 1'b1;
        rdy  = 1'b1;
        cycle(0, 0, 32'hF);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 32'hF);
            check("r035_sel", 32'(b4.select), 32'h0);
            check("r035_ptr", 32'(b4.ptr), 32'h0);
        end
        lock = 1'b0;
        cycle(0, 0, 32'hF);
        check("r035_unlock", 32'(b4.select), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
